// File: rtl/priority_arbiter_enc.sv
// Registered N-input priority arbiter with a held one-hot grant and binary index.
// Fixed (MSB-first) or round-robin priority; the held grant is released by ack.
module priority_arbiter_enc #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             ack,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     grant
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [IDX_W-1:0]   search_top;
    logic [IDX_W-1:0]   cand;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [N-1:0]       win_grant;

    // ptr_d feeds the search in the same cycle so an ack re-arbitrates with the
    // just-rotated pointer; index arithmetic wraps naturally because N is a power of two.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == HOLD && ack && mode) begin
            ptr_d = idx_q - IDX_W'(1);
        end

        search_top = mode ? ptr_d : IDX_W'(N - 1);
        cand       = '0;
        win_found  = 1'b0;
        win_idx    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand = search_top - IDX_W'(j);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        win_grant          = '0;
        win_grant[win_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        grant_d = grant_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    idx_d   = win_idx;
                    grant_d = win_grant;
                end
            end
            HOLD: begin
                if (ack) begin
                    if (win_found) begin
                        idx_d   = win_idx;
                        grant_d = win_grant;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
            ptr_q   <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid = valid_q;
    assign idx   = idx_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_priority_arbiter_enc.sv
// Scoreboard bench for priority_arbiter_enc: directed N=8 scenarios with fixed
// expectations, then random traffic on N=4 and N=16 against a behavioural model.
module tb_priority_arbiter_enc;

    typedef struct {
        logic        v;
        int          i;
        logic [15:0] g;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b0, mode8 = 1'b0, ack8 = 1'b0;
    logic [7:0]  req8 = '0;
    logic        valid8;
    logic [2:0]  idx8;
    logic [7:0]  grant8;

    logic        rst4 = 1'b0, mode4 = 1'b0, ack4 = 1'b0;
    logic [3:0]  req4 = '0;
    logic        valid4;
    logic [1:0]  idx4;
    logic [3:0]  grant4;

    logic        rst16 = 1'b0, mode16 = 1'b0, ack16 = 1'b0;
    logic [15:0] req16 = '0;
    logic        valid16;
    logic [3:0]  idx16;
    logic [15:0] grant16;

    int errors = 0;
    int checks = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q16[$];

    int m4v, m4i, m4p, m16v, m16i, m16p;

    priority_arbiter_enc #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst8), .req(req8), .mode(mode8), .ack(ack8),
        .valid(valid8), .idx(idx8), .grant(grant8)
    );

    priority_arbiter_enc #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst4), .req(req4), .mode(mode4), .ack(ack4),
        .valid(valid4), .idx(idx4), .grant(grant4)
    );

    priority_arbiter_enc #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst16), .req(req16), .mode(mode16), .ack(ack16),
        .valid(valid16), .idx(idx16), .grant(grant16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t makeExp(input logic v, input int i);
        exp_t e;
        e.v = v;
        e.i = v ? i : 0;
        e.g = v ? (16'd1 << i) : 16'd0;
        return e;
    endfunction

    // Walks the search order start, start-1, ... modulo n and returns the first hit.
    function automatic int pickWinner(input int n, input logic [15:0] r, input logic m, input int p);
        int start;
        int c;
        start = m ? p : n - 1;
        for (int j = 0; j < n; j++) begin
            c = (start - j + n) % n;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelStep(input int n, input logic [15:0] r, input logic m, input logic a,
                             input logic rn, inout int mv, inout int mi, inout int mp);
        int w;
        if (!rn) begin
            mv = 0;
            mi = 0;
            mp = n - 1;
        end else if (mv == 0) begin
            w = pickWinner(n, r, m, mp);
            if (w >= 0) begin
                mv = 1;
                mi = w;
            end
        end else if (a) begin
            if (m) mp = (mi - 1 + n) % n;
            w = pickWinner(n, r, m, mp);
            if (w >= 0) begin
                mi = w;
            end else begin
                mv = 0;
                mi = 0;
            end
        end
    endtask

    // One directed N=8 cycle: drive, push the expectation, then compare after the edge.
    task automatic applyStimulus(input string tag, input logic [7:0] r, input logic m, input logic a,
                                 input logic rn, input logic ev, input int ei);
        exp_t e;
        @(negedge clk);
        req8  = r;
        mode8 = m;
        ack8  = a;
        rst8  = rn;
        q8.push_back(makeExp(ev, ei));
        @(posedge clk);
        #1;
        e = q8.pop_front();
        checkOutput({tag, ".valid"}, 32'(valid8), 32'(e.v));
        checkOutput({tag, ".idx"},   32'(idx8),   32'(e.i));
        checkOutput({tag, ".grant"}, 32'(grant8), 32'(e.g[7:0]));
    endtask

    initial begin
        exp_t e;
        int   rrSeq[8];

        applyStimulus("reset", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        applyStimulus("fixed_first", 8'b0010_0110, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        for (int k = 0; k < 3; k++) applyStimulus("fixed_hold", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        applyStimulus("fixed_release", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        applyStimulus("rr_first", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 7);
        rrSeq = '{6, 5, 4, 3, 2, 1, 0, 7};
        for (int k = 0; k < 8; k++) applyStimulus("rr_rotate", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, rrSeq[k]);
        applyStimulus("rr_drain", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        applyStimulus("alt_reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus("alt_first", 8'b1000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 7);
        applyStimulus("alt_0", 8'b1000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        applyStimulus("alt_7", 8'b1000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 7);
        applyStimulus("alt_0b", 8'b1000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        applyStimulus("alt_drain", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        applyStimulus("mid_grant", 8'h08, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        applyStimulus("mid_regrant", 8'h08, 1'b1, 1'b1, 1'b1, 1'b1, 3);
        applyStimulus("mid_reset", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus("post_reset", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 7);
        applyStimulus("post_drain", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        applyStimulus("idle_ack", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus("idle_ack2", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        applyStimulus("modesw_grant", 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        applyStimulus("modesw_hold", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        applyStimulus("modesw_ack", 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        applyStimulus("modesw_drain", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        m4v = 0; m4i = 0; m4p = 3;
        m16v = 0; m16i = 0; m16p = 15;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            rst4   = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            req4   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            mode4  = 1'($urandom);
            ack4   = 1'($urandom);
            rst16  = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            req16  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
            mode16 = 1'($urandom);
            ack16  = 1'($urandom);
            modelStep(4, {12'h0, req4}, mode4, ack4, rst4, m4v, m4i, m4p);
            q4.push_back(makeExp(m4v != 0, m4i));
            modelStep(16, req16, mode16, ack16, rst16, m16v, m16i, m16p);
            q16.push_back(makeExp(m16v != 0, m16i));
            @(posedge clk);
            #1;
            e = q4.pop_front();
            checkOutput("rand4.valid", 32'(valid4), 32'(e.v));
            checkOutput("rand4.idx",   32'(idx4),   32'(e.i));
            checkOutput("rand4.grant", 32'(grant4), 32'(e.g[3:0]));
            checkOutput("rand4.inv", 32'($onehot0(grant4) && ((grant4 != 0) == valid4)
                                         && (valid4 || idx4 == 0)), 32'd1);
            e = q16.pop_front();
            checkOutput("rand16.valid", 32'(valid16), 32'(e.v));
            checkOutput("rand16.idx",   32'(idx16),   32'(e.i));
            checkOutput("rand16.grant", 32'(grant16), 32'(e.g));
            checkOutput("rand16.inv", 32'($onehot0(grant16) && ((grant16 != 0) == valid16)
                                          && (valid16 || idx16 == 0)), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
